gpio_mmio: RTL

//  Memory-mapped LED/button peripheral on the core data bus, used next to main_mem.

---
 rtl/gpio_mmio.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gpio_mmio.sv
// Memory-mapped LED/button peripheral: byte-lane LED register, synchronised and
// debounced buttons, sticky press events (W1C) and a masked level interrupt.
module gpio_mmio #(
    parameter int unsigned N_LED           = 8,
    parameter int unsigned N_BTN           = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter logic [31:0] LED_RESET       = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Sel,
    input  logic [31:0]      DAddr,
    input  logic [31:0]      DWData,
    input  logic             DWE,
    input  logic [1:0]       DWidth,
    output logic [31:0]      DRData,
    input  logic [N_BTN-1:0] btn,
    output logic [N_LED-1:0] led,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_LED-1:0] led_q, led_d;
    logic [N_BTN-1:0] irq_en_q, irq_en_d;
    logic [N_BTN-1:0] btn_evt_q, btn_evt_d;
    logic [N_BTN-1:0] state_q, state_d;
    logic [N_BTN-1:0] sync0_q, sync1_q;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic             irq_q, irq_d;

    logic [31:0]      lane_mask;
    logic             wr_en;
    logic [N_BTN-1:0] pin_pressed;
    logic [N_BTN-1:0] evt_clr;
    logic [N_BTN-1:0] rise;
    logic             unused_bits;

    // Normalise pins so that 1 always means pressed.
    assign pin_pressed = BTN_ACTIVE_LOW ? ~btn : btn;
    assign wr_en       = Sel & DWE;
    assign unused_bits = ^{DAddr[31:4], DWData, lane_mask};

    // Byte-lane enables from access width and low address bits.
    always_comb begin
        lane_mask = 32'h0;
        case (DWidth)
            2'b00:   lane_mask = 32'h0000_00FF << {DAddr[1:0], 3'b000};
            2'b01:   lane_mask = DAddr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            2'b10:   lane_mask = 32'hFFFF_FFFF;
            default: lane_mask = 32'h0;
        endcase
    end

    // Register writes, debounce counters, press detection and interrupt level.
    always_comb begin
        led_d    = led_q;
        irq_en_d = irq_en_q;
        evt_clr  = '0;
        state_d  = state_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
        end

        if (wr_en) begin
            case (DAddr[3:2])
                2'd0: led_d = (led_q & ~N_LED'(lane_mask)) | (N_LED'(DWData) & N_LED'(lane_mask));
                2'd2: evt_clr = N_BTN'(DWData) & N_BTN'(lane_mask);
                2'd3: irq_en_d = (irq_en_q & ~N_BTN'(lane_mask)) | (N_BTN'(DWData) & N_BTN'(lane_mask));
                default: ;
            endcase
        end

        for (int i = 0; i < N_BTN; i++) begin
            if (sync1_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    state_d[i] = sync1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        rise      = state_d & ~state_q;
        btn_evt_d = (btn_evt_q & ~evt_clr) | rise;
        irq_d     = |(btn_evt_q & irq_en_q);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q     <= N_LED'(LED_RESET);
            irq_en_q  <= '0;
            btn_evt_q <= '0;
            state_q   <= '0;
            sync0_q   <= '0;
            sync1_q   <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            led_q     <= led_d;
            irq_en_q  <= irq_en_d;
            btn_evt_q <= btn_evt_d;
            state_q   <= state_d;
            sync0_q   <= pin_pressed;
            sync1_q   <= sync0_q;
            irq_q     <= irq_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-latency read mux; idle bus reads zero.
    always_comb begin
        DRData = 32'h0;
        if (Sel) begin
            case (DAddr[3:2])
                2'd0:    DRData = 32'(led_q);
                2'd1:    DRData = 32'(state_q);
                2'd2:    DRData = 32'(btn_evt_q);
                default: DRData = 32'(irq_en_q);
            endcase
        end
    end

    assign led = led_q;
    assign irq = irq_q;

endmodule
